// File: rtl/axis_split_router_4.sv
`default_nettype none
// ============================================================================
//  Module   : axis_split_router_4
//  Purpose  : Routes frames from one AXI-Stream input to one of four AXI-Stream
//             outputs. The destination is decoded from a 3-bit field in the
//             first beat of each frame. The output is selected for the whole
//             frame and frames are never interleaved. A single output register
//             stage gives one beat per cycle with same-cycle backpressure.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             s_axis_*               - upstream stream (tvalid/tdata/tlast/tready)
//             m00..m03_axis_*        - four downstream streams
//             busy                   - frame in progress (state not IDLE)
//             drop_count             - saturating dropped-frame count
//                                      (AXIS_SPLIT_DROP_EN builds only)
//  Options  : `define AXIS_SPLIT_DROP_EN - frames whose destination is 4..7
//             are discarded and counted. When undefined, they go to
//             output dest[1:0].
//  Revision : 1.0 - initial release
// ============================================================================
module axis_split_router_4 #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_LSB   = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  m01_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic                  m01_axis_tlast,
    input  logic                  m01_axis_tready,
    output logic                  m02_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m02_axis_tdata,
    output logic                  m02_axis_tlast,
    input  logic                  m02_axis_tready,
    output logic                  m03_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m03_axis_tdata,
    output logic                  m03_axis_tlast,
    input  logic                  m03_axis_tready,
`ifdef AXIS_SPLIT_DROP_EN
    output logic [15:0]           drop_count,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;
    logic [1:0]              r_sel;

    logic [3:0]              w_m_ready;
    logic                    w_sel_ready;
    logic [1:0]              w_dest_sel;
    logic                    w_drop_first;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_drop_beat;

    assign w_m_ready   = {m03_axis_tready, m02_axis_tready, m01_axis_tready, m00_axis_tready};
    assign w_sel_ready = w_m_ready[r_sel];
    assign w_dest_sel  = s_axis_tdata[DEST_LSB+1:DEST_LSB];

`ifdef AXIS_SPLIT_DROP_EN
    assign w_drop_first = s_axis_tdata[DEST_LSB+2];
    // Dropped beats never touch the output register, so DROP can always accept.
    assign w_ready      = (r_state == ST_DROP) | ~r_out_valid | w_sel_ready;
`else
    assign w_drop_first = 1'b0;
    assign w_ready      = ~r_out_valid | w_sel_ready;
`endif

    assign s_axis_tready = w_ready & ~rst;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign busy          = (r_state != ST_IDLE) & ~rst;

    // Next-state decode and beat classification
    always_comb begin
        w_state_next = r_state;
        w_drop_beat  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_drop_first) begin
                        w_drop_beat = 1'b1;
                        if (!s_axis_tlast) w_state_next = ST_DROP;
                    end else if (!s_axis_tlast) begin
                        w_state_next = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (w_accept && s_axis_tlast) w_state_next = ST_IDLE;
            end
`ifdef AXIS_SPLIT_DROP_EN
            ST_DROP: begin
                w_drop_beat = w_accept;
                if (w_accept && s_axis_tlast) w_state_next = ST_IDLE;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and output register. A beat is only accepted when the register is
    // empty or draining this cycle, so reloading r_sel on a first beat cannot
    // redirect a beat still waiting to leave.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sel       <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && !w_drop_beat) begin
                r_out_valid <= 1'b1;
                r_out_data  <= s_axis_tdata;
                r_out_last  <= s_axis_tlast;
                if (r_state == ST_IDLE) r_sel <= w_dest_sel;
            end else if (w_sel_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef AXIS_SPLIT_DROP_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= 16'd0;
        end else if (w_drop_beat && s_axis_tlast && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign m00_axis_tvalid = r_out_valid & (r_sel == 2'd0) & ~rst;
    assign m01_axis_tvalid = r_out_valid & (r_sel == 2'd1) & ~rst;
    assign m02_axis_tvalid = r_out_valid & (r_sel == 2'd2) & ~rst;
    assign m03_axis_tvalid = r_out_valid & (r_sel == 2'd3) & ~rst;

    assign m00_axis_tdata  = r_out_data;
    assign m01_axis_tdata  = r_out_data;
    assign m02_axis_tdata  = r_out_data;
    assign m03_axis_tdata  = r_out_data;

    assign m00_axis_tlast  = r_out_last;
    assign m01_axis_tlast  = r_out_last;
    assign m02_axis_tlast  = r_out_last;
    assign m03_axis_tlast  = r_out_last;

endmodule
`default_nettype wire
